// File: rtl/wave_display.sv
// Waveform plotter: draws a 256-sample trace (2 px per sample) in the window x 512..1023, y 0..511.
// Latency: x/y/valid to valid_pixel, r/g/b and wave_display_idle is 2 clk; read_address is combinational.
// Backpressure: none, the pixel stream is free-running; wave_display_idle tells capture when a RAM swap is safe.
module wave_display (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] x,
    input  logic [9:0]  y,
    input  logic        valid,
    input  logic        read_index,
    input  logic [7:0]  read_value,
    output logic [8:0]  read_address,
    output logic        valid_pixel,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        wave_display_idle
);

    // Stage-0 decode
    logic       w_in_win;
    logic       w_first_col;
    logic       w_unused;

    // Stage-1 registers; read_value lines up with these
    logic       r_s1_in_win;
    logic       r_s1_first;
    logic       r_s1_y9;
    logic [7:0] r_s1_row;
    logic [7:0] r_s1_col;

    // Column history: last registered column and the samples of the current and previous columns
    logic [7:0] r_last_col;
    logic [7:0] r_cur_s;
    logic [7:0] r_prev_s;

    // Stage-1 combinational segment test
    logic       w_col_changed;
    logic [7:0] w_prev_s;
    logic [7:0] w_h_prev;
    logic [7:0] w_h_cur;
    logic [7:0] w_lo;
    logic [7:0] w_hi;
    logic       w_hit;

    // Stage-2 output registers
    logic       r_valid_pixel;
    logic [7:0] r_color;
    logic       r_idle;

    assign w_in_win     = valid & (x[10:9] == 2'b01) & ~y[9];
    assign w_first_col  = (x[8:1] == 8'd0);
    assign read_address = {read_index, x[8:1]};

    // Pixel bit 0 of x and y is ignored: every sample and every plotted row is 2 pixels wide.
    assign w_unused = ^{x[0], y[0]};

    // Stage 1: register window membership, row/column and first-column flag alongside the RAM read
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s1_in_win <= 1'b0;
            r_s1_first  <= 1'b0;
            r_s1_y9     <= 1'b0;
            r_s1_row    <= 8'd0;
            r_s1_col    <= 8'd0;
        end else begin
            r_s1_in_win <= w_in_win;
            r_s1_first  <= w_first_col;
            r_s1_y9     <= y[9];
            r_s1_row    <= y[8:1];
            r_s1_col    <= x[8:1];
        end
    end

    // Pick the previous-column sample; the first column of a row joins only to itself
    always_comb begin
        w_col_changed = (r_s1_col != r_last_col);
        w_prev_s      = r_prev_s;
        if (r_s1_first) begin
            w_prev_s = read_value;
        end else if (w_col_changed) begin
            w_prev_s = r_cur_s;
        end
        // Larger samples plot higher on screen, i.e. at smaller row numbers
        w_h_prev = ~w_prev_s;
        w_h_cur  = ~read_value;
        w_lo     = w_h_cur;
        w_hi     = w_h_prev;
        if (w_h_prev < w_h_cur) begin
            w_lo = w_h_prev;
            w_hi = w_h_cur;
        end
        w_hit = r_s1_in_win & (r_s1_row >= w_lo) & (r_s1_row <= w_hi);
    end

    // Track the column history so the next column sees this one as its predecessor
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_last_col <= 8'd0;
            r_cur_s    <= 8'd0;
            r_prev_s   <= 8'd0;
        end else begin
            r_last_col <= r_s1_col;
            r_cur_s    <= read_value;
            r_prev_s   <= w_prev_s;
        end
    end

    // Stage 2: register the pixel decision, its colour and the idle flag together
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid_pixel <= 1'b0;
            r_color       <= 8'h00;
            r_idle        <= 1'b0;
        end else begin
            r_valid_pixel <= w_hit;
            r_color       <= w_hit ? 8'hFF : 8'h00;
            r_idle        <= r_s1_y9;
        end
    end

    assign valid_pixel       = r_valid_pixel;
    assign r                 = r_color;
    assign g                 = r_color;
    assign b                 = r_color;
    assign wave_display_idle = r_idle;

endmodule

// File: tb/tb_wave_display.sv
// Bench for wave_display: raster sweeps over a modelled sample RAM, checked against a sample-level trace model.
// Latency: expects outputs 2 clk after x/y are applied (one cycle after the sampling edge of the next drive).
// Backpressure: none; the bench drives one pixel per clock.
module tb_wave_display;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] x;
    logic [9:0]  y;
    logic        valid;
    logic        read_index;
    logic [7:0]  read_value;
    logic [8:0]  read_address;
    logic        valid_pixel;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        wave_display_idle;

    logic [7:0]  mem [0:511];
    int          total = 0;
    int          bad   = 0;
    bit          e1    = 1'b0;
    bit          i1    = 1'b0;

    always #5 clk = ~clk;

    wave_display dut (
        .clk               (clk),
        .reset             (reset),
        .x                 (x),
        .y                 (y),
        .valid             (valid),
        .read_index        (read_index),
        .read_value        (read_value),
        .read_address      (read_address),
        .valid_pixel       (valid_pixel),
        .r                 (r),
        .g                 (g),
        .b                 (b),
        .wave_display_idle (wave_display_idle)
    );

    // Synchronous sample RAM: data one clock after the address
    always @(posedge clk) read_value <= mem[read_address];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Trace model: a lit pixel lies on the vertical span between the heights of column c-1 and c
    function automatic bit model_pix(input int xx, input int yy, input bit v, input bit idx);
        int c, cur, prev, hc, hp, row, lo, hi;
        if (!v || xx < 512 || xx > 1023 || yy > 511) return 1'b0;
        c    = (xx / 2) % 256;
        cur  = int'(mem[9'(int'(idx) * 256 + c)]);
        prev = (c == 0) ? cur : int'(mem[9'(int'(idx) * 256 + c - 1)]);
        hc   = 255 - cur;
        hp   = 255 - prev;
        lo   = (hc < hp) ? hc : hp;
        hi   = (hc < hp) ? hp : hc;
        row  = (yy / 2) % 256;
        return (row >= lo) && (row <= hi);
    endfunction

    // One pixel clock: apply x/y, check the address, then check the outputs of the previous pixel
    task automatic drive(input int xx, input int yy, input bit v);
        bit pix;
        bit rst_now;
        bit ev;
        bit iv;
        x       = 11'(xx);
        y       = 10'(yy);
        valid   = v;
        pix     = model_pix(xx, yy, v, read_index);
        rst_now = reset;
        #1;
        chk("addr", 32'(read_address), 32'({read_index, 8'((xx / 2) % 256)}));
        @(posedge clk);
        #1;
        ev = rst_now ? e1 : 1'b0;
        iv = rst_now ? i1 : 1'b0;
        chk("vp", 32'(valid_pixel), 32'(ev));
        chk("rgb", 32'({r, g, b}), ev ? 32'hFFFFFF : 32'h0);
        chk("idle", 32'(wave_display_idle), 32'(iv));
        e1 = rst_now ? pix : 1'b0;
        i1 = rst_now ? (yy >= 512) : 1'b0;
    endtask

    task automatic sweep(input int x0, input int x1, input int yy);
        for (int xx = x0; xx <= x1; xx++) drive(xx, yy, 1'b1);
    endtask

    task automatic flush();
        drive(1100, 600, 1'b1);
        drive(1100, 600, 1'b1);
    endtask

    task automatic hold_check(input int xx, input int yy, input bit expv, input string tag);
        repeat (3) drive(xx, yy, 1'b1);
        chk(tag, 32'(valid_pixel), 32'(expv));
    endtask

    task automatic fill(input int val);
        for (int i = 0; i < 512; i++) mem[i] = (val < 0) ? 8'($urandom_range(0, 255)) : 8'(val);
    endtask

    initial begin
        reset      = 1'b0;
        x          = 11'd0;
        y          = 10'd0;
        valid      = 1'b0;
        read_index = 1'b0;
        fill(8'h80);

        // Reset state
        repeat (3) drive(600, 100, 1'b1);
        chk("reset_vp", 32'(valid_pixel), 32'h0);
        chk("reset_idle", 32'(wave_display_idle), 32'h0);
        reset = 1'b1;
        flush();

        // Flat trace: only row 0x7F lit across the window
        for (int yy = 250; yy <= 259; yy++) sweep(508, 1027, yy);
        flush();

        // Reset mid-frame during a lit pixel
        hold_check(512, 254, 1'b1, "flat_lit_512");
        reset = 1'b0;
        drive(512, 254, 1'b1);
        chk("rst_vp0", 32'(valid_pixel), 32'h0);
        chk("rst_rgb0", 32'({r, g, b}), 32'h0);
        drive(512, 254, 1'b1);
        drive(512, 254, 1'b1);
        reset = 1'b1;
        drive(512, 254, 1'b1);
        chk("rel_vp_first", 32'(valid_pixel), 32'h0);
        drive(512, 254, 1'b1);
        chk("rel_vp_resume", 32'(valid_pixel), 32'h1);
        flush();

        // Step between columns 10 and 11
        mem[10] = 8'h80;
        mem[11] = 8'h90;
        for (int row = 8'h6D; row <= 8'h81; row++) sweep(508, 540, 2 * row);
        sweep(508, 534, 2 * 8'h6F);
        hold_check(534, 2 * 8'h6F, 1'b1, "step534_top");
        hold_check(534, 2 * 8'h6E + 1, 1'b0, "step534_above");
        hold_check(535, 2 * 8'h7F + 1, 1'b1, "step535_bottom");
        hold_check(535, 2 * 8'h80, 1'b0, "step535_below");
        flush();
        sweep(508, 532, 2 * 8'h7F);
        hold_check(532, 2 * 8'h7F, 1'b1, "step532_flat");
        hold_check(533, 2 * 8'h7E, 1'b0, "step533_above");
        hold_check(533, 2 * 8'h80, 1'b0, "step533_below");
        flush();

        // Address mapping and out-of-window columns
        read_index = 1'b1;
        x          = 11'd700;
        #1;
        chk("addr_15e", 32'(read_address), 32'h15E);
        read_index = 1'b0;
        #1;
        chk("addr_05e", 32'(read_address), 32'h05E);
        fill(-1);
        for (int k = 0; k < 6; k++) begin
            read_index = 1'($urandom_range(0, 1));
            drive(300, int'($urandom_range(0, 511)), 1'b1);
        end
        chk("x300_vp", 32'(valid_pixel), 32'h0);
        read_index = 1'b0;
        flush();

        // Row start: previous row ends at 0x00, column 0 is 0xFF
        mem[255] = 8'h00;
        mem[0]   = 8'hFF;
        sweep(510, 1023, 2);
        hold_check(512, 0, 1'b1, "rowstart_row0");
        hold_check(513, 1, 1'b1, "rowstart_row0b");
        hold_check(512, 2, 1'b0, "rowstart_row1");
        hold_check(512, 510, 1'b0, "rowstart_rowff");
        flush();

        // Idle flag follows y[9] with 2 clk latency; read_index toggles are invisible while idle
        repeat (3) drive(1100, 511, 1'b1);
        drive(1100, 512, 1'b1);
        chk("idle_pre", 32'(wave_display_idle), 32'h0);
        drive(1100, 512, 1'b1);
        chk("idle_rise", 32'(wave_display_idle), 32'h1);
        for (int k = 0; k < 8; k++) begin
            read_index = ~read_index;
            drive(int'($urandom_range(512, 1023)), int'($urandom_range(512, 1023)), 1'b1);
            chk("idle_rgb", 32'({r, g, b}), 32'h0);
        end
        drive(1100, 0, 1'b1);
        chk("idle_hold", 32'(wave_display_idle), 32'h1);
        drive(1100, 0, 1'b1);
        chk("idle_fall", 32'(wave_display_idle), 32'h0);
        flush();

        // Random RAM contents, random rows and valid per pixel
        for (int s = 0; s < 12; s++) begin
            int x0;
            int x1;
            fill(-1);
            read_index = 1'($urandom_range(0, 1));
            x0 = int'($urandom_range(500, 512));
            x1 = int'($urandom_range(520, 1030));
            for (int xx = x0; xx <= x1; xx++)
                drive(xx, int'($urandom_range(0, 1023)), ($urandom_range(0, 7) != 0));
            flush();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
